// File: rtl/line_mem_responder_pkg.sv
// Shared definitions for the line-memory responder: FSM encoding and
// width helpers used by the responder, the arbiter and the cache stages.
package line_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte-offset bits inside one line (log2 of bytes per line).
  function automatic int lineOffsetBits(input int lineWidth);
    return $clog2(lineWidth / 8);
  endfunction

  // Bits needed to index the line store.
  function automatic int indexBits(input int memLines);
    return $clog2(memLines);
  endfunction

  // Latency counter width; kept at least one bit so latency=1 still builds.
  function automatic int counterBits(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/line_mem_responder_line_store.sv
// Single-port line storage: synchronous write, registered read-before-write.
// No reset: contents survive a responder reset.
module line_store #(
  parameter int cache_line_width = 256,
  parameter int mem_lines        = 64,
  parameter int idxWidth         = 6
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [idxWidth-1:0]         idx,
  input  logic [cache_line_width-1:0] wdata,
  output logic [cache_line_width-1:0] rdata
);

  logic [cache_line_width-1:0] mem [mem_lines];

  // Commit writes and register the addressed line every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/line_mem_responder.sv
// Responder side of the petition/serviceReady line-memory protocol.
// Handshake: petition is the request valid and stays high until the requester
// sees serviceReady; it is only sampled in IDLE, and serviceReady is a
// registered one-cycle pulse marking completion of the accepted request.
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int cache_line_width = 256,
  parameter int addr_width       = 16,
  parameter int mem_lines        = 64,
  parameter int latency          = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        petition,
  input  logic [addr_width-1:0]       address,
  input  logic                        we,
  input  logic [cache_line_width-1:0] data_write,
  output logic                        serviceReady,
  output logic [cache_line_width-1:0] data_read,
  output logic                        busy,
  output logic [1:0]                  debugState
);

  localparam int OFS   = lineOffsetBits(cache_line_width);
  localparam int IDX_W = indexBits(mem_lines);
  localparam int CNT_W = counterBits(latency);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(latency - 1);

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [IDX_W-1:0]            capIdx;
  logic                        capWe;
  logic [cache_line_width-1:0] capData;

  logic [IDX_W-1:0]            reqIdx;
  logic [IDX_W-1:0]            storeIdx;
  logic                        storeWe;
  logic                        finishing;
  logic [cache_line_width-1:0] storeRdata;
  logic                        unusedAddrBits;

  // Upper address bits alias onto the same line; offset bits select bytes.
  assign reqIdx         = address[OFS +: IDX_W];
  assign unusedAddrBits = ^address;
  assign finishing      = (state == BUSY) && (cnt == '0);
  // In IDLE the store already looks at the incoming index so a latency of
  // one still finds the line registered by the time the access completes.
  assign storeIdx       = (state == IDLE) ? reqIdx : capIdx;
  assign storeWe        = finishing && capWe;
  assign debugState     = state;

  line_store #(
    .cache_line_width(cache_line_width),
    .mem_lines       (mem_lines),
    .idxWidth        (IDX_W)
  ) u_store (
    .clk  (clk),
    .we   (storeWe),
    .idx  (storeIdx),
    .wdata(capData),
    .rdata(storeRdata)
  );

  // Request FSM: capture on acceptance, count down, complete, pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      serviceReady <= 1'b0;
      data_read    <= '0;
      busy         <= 1'b0;
      capIdx       <= '0;
      capWe        <= 1'b0;
      capData      <= '0;
    end else begin
      case (state)
        IDLE: begin
          serviceReady <= 1'b0;
          if (petition) begin
            capIdx  <= reqIdx;
            capWe   <= we;
            capData <= data_write;
            cnt     <= CNT_LOAD;
            state   <= BUSY;
            busy    <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state        <= DONE;
            serviceReady <= 1'b1;
            if (!capWe) begin
              data_read <= storeRdata;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          serviceReady <= 1'b0;
          busy         <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          serviceReady <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: two instances (latency 5 and latency 1)
// driven independently, checked every cycle against a transaction-level model.
module tb_line_mem_responder;

  localparam int W    = 256;
  localparam int AW   = 16;
  localparam int ML   = 64;
  localparam int OFS  = 5;
  localparam int LAT0 = 5;
  localparam int LAT1 = 1;

  logic          clk;
  logic          rst_n;
  logic          pet  [2];
  logic [AW-1:0] addr [2];
  logic          we   [2];
  logic [W-1:0]  wd   [2];
  logic          sr   [2];
  logic [W-1:0]  rd   [2];
  logic          bz   [2];
  logic [1:0]    st   [2];

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  line_mem_responder #(.cache_line_width(W), .addr_width(AW), .mem_lines(ML), .latency(LAT0)) dut0 (
    .clk(clk), .reset(rst_n), .petition(pet[0]), .address(addr[0]), .we(we[0]),
    .data_write(wd[0]), .serviceReady(sr[0]), .data_read(rd[0]), .busy(bz[0]), .debugState(st[0])
  );

  line_mem_responder #(.cache_line_width(W), .addr_width(AW), .mem_lines(ML), .latency(LAT1)) dut1 (
    .clk(clk), .reset(rst_n), .petition(pet[1]), .address(addr[1]), .we(we[1]),
    .data_write(wd[1]), .serviceReady(sr[1]), .data_read(rd[1]), .busy(bz[1]), .debugState(st[1])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // Each instance: at most one request in flight, identified by its age in
  // edges since acceptance. At age == latency the access happens and the
  // completion pulse is visible; one edge later the responder is free again.
  bit           mBusy      [2];
  int           mAge       [2];
  int           mIdx       [2];
  bit           mWe        [2];
  logic [W-1:0] mData      [2];
  logic [W-1:0] mMem       [2][ML];
  bit           mKnown     [2][ML];
  logic [W-1:0] mRead      [2];
  bit           mReadKnown [2];
  bit           mSr        [2];

  function automatic int latOf(input int u);
    return (u == 0) ? LAT0 : LAT1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int age;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        mBusy[u]      <= 1'b0;
        mSr[u]        <= 1'b0;
        mRead[u]      <= '0;
        mReadKnown[u] <= 1'b1;
      end else if (!mBusy[u]) begin
        mSr[u] <= 1'b0;
        if (pet[u] === 1'b1) begin
          mBusy[u] <= 1'b1;
          mAge[u]  <= 0;
          mIdx[u]  <= int'((addr[u] >> OFS) % ML);
          mWe[u]   <= we[u];
          mData[u] <= wd[u];
        end
      end else begin
        age = mAge[u] + 1;
        mAge[u] <= age;
        if (age == latOf(u)) begin
          mSr[u] <= 1'b1;
          if (mWe[u]) begin
            mMem[u][mIdx[u]]   <= mData[u];
            mKnown[u][mIdx[u]] <= 1'b1;
          end else begin
            mRead[u]      <= mMem[u][mIdx[u]];
            mReadKnown[u] <= mKnown[u][mIdx[u]];
          end
        end else if (age > latOf(u)) begin
          mBusy[u] <= 1'b0;
          mSr[u]   <= 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chkBit(input string name, input int u, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s u=%0d got %b exp %b t=%0t", name, u, got, exp, $time);
    end
  endtask

  task automatic chkWide(input string name, input int u, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s u=%0d got %h exp %h t=%0t", name, u, got, exp, $time);
    end
  endtask

  task automatic chkInt(input string name, input int u, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s u=%0d got %0d exp %0d t=%0t", name, u, got, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        chkBit("serviceReady", u, sr[u], mSr[u]);
        chkBit("busy", u, bz[u], mBusy[u]);
        if (mReadKnown[u]) chkWide("data_read", u, rd[u], mRead[u]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] randLine();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at a negedge; returns negedges until serviceReady is seen, or -1.
  task automatic waitSr(input int u, input bit chaos, output int k);
    bit seen;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (sr[u] === 1'b1) seen = 1'b1;
      else if (chaos) begin
        addr[u] = AW'($urandom);
        wd[u]   = randLine();
        we[u]   = 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout u=%0d no serviceReady within %0d cycles", u, k);
      k = -1;
    end
  endtask

  // One full transaction; lat = edges from acceptance to the pulse.
  task automatic txn(input int u, input logic [AW-1:0] a, input logic w, input logic [W-1:0] d,
                     input bit chaos, output int lat);
    int k;
    pet[u]  = 1'b1;
    addr[u] = a;
    we[u]   = w;
    wd[u]   = d;
    waitSr(u, chaos, k);
    pet[u] = 1'b0;
    lat = (k < 0) ? -1 : k - 1;
    @(negedge clk);
  endtask

  task automatic sweep(input int u);
    int lat;
    for (int i = 0; i < ML; i++) begin
      txn(u, AW'(i << OFS), 1'b1, {(W/32){32'hC0DE0000 | 32'(i)}}, 1'b0, lat);
    end
  endtask

  task automatic runRandom(input int u, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      txn(u, AW'($urandom), 1'($urandom_range(0, 1)), randLine(), 1'($urandom_range(0, 1)), lat);
      chkInt("latency_rand", u, lat, latOf(u));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic writeRead(input int u, input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                           input logic [W-1:0] d, input bit chaos, input int expLat, input string name);
    int lat;
    txn(u, wa, 1'b1, d, chaos, lat);
    chkInt({name, "_wlat"}, u, lat, expLat);
    txn(u, ra, 1'b0, ~d, chaos, lat);
    chkInt({name, "_rlat"}, u, lat, expLat);
    chkWide({name, "_data"}, u, rd[u], d);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, pulses;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      pet[u] = 1'b1; addr[u] = 16'h0040; we[u] = 1'b1; wd[u] = '1;
    end
    @(posedge clk);
    armed = 1'b1;
    repeat (3) @(negedge clk);
    // reset held with petition high: nothing starts
    for (int u = 0; u < 2; u++) begin
      chkBit("rst_sr", u, sr[u], 1'b0);
      chkBit("rst_busy", u, bz[u], 1'b0);
      chkWide("rst_data", u, rd[u], '0);
      chkInt("rst_state", u, int'(st[u]), 0);
    end
    pet[0] = 1'b0; pet[1] = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);

    // fill every line with a known pattern
    fork
      sweep(0);
      sweep(1);
    join

    // write then read back, latency measured per instance
    writeRead(0, 16'h0040, 16'h0040, {32{8'hA5}}, 1'b0, 5, "wr_rd");
    writeRead(1, 16'h0040, 16'h0040, {32{8'hA5}}, 1'b0, 1, "wr_rd");

    // held petition: back-to-back transaction with one idle cycle between
    pet[0] = 1'b1; addr[0] = 16'h0040; we[0] = 1'b0; wd[0] = '0;
    waitSr(0, 1'b0, k);
    chkInt("held_first_lat", 0, k - 1, 5);
    @(negedge clk);
    chkBit("held_idle_gap", 0, bz[0], 1'b0);
    @(negedge clk);
    chkBit("held_reaccept", 0, bz[0], 1'b1);
    waitSr(0, 1'b0, k);
    chkInt("held_second_wait", 0, k, 5);
    pet[0] = 1'b0;
    chkWide("held_data", 0, rd[0], {32{8'hA5}});
    @(negedge clk);

    // reset in the middle of a write aborts it
    pet[0] = 1'b1; addr[0] = 16'h0020; we[0] = 1'b1; wd[0] = '1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    pet[0] = 1'b0;
    @(negedge clk);
    chkBit("abort_busy", 0, bz[0], 1'b0);
    #2 rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (sr[0] === 1'b1) pulses++;
    end
    chkInt("abort_no_pulse", 0, pulses, 0);
    txn(0, 16'h0020, 1'b0, '0, 1'b0, k);
    chkWide("abort_old_data", 0, rd[0], {8{32'hC0DE0001}});

    // aliasing: 0x0800 maps to the same line as 0x0000
    writeRead(0, 16'h0000, 16'h0800, {16{16'h1234}}, 1'b0, 5, "alias");
    writeRead(1, 16'h0000, 16'h0800, {16{16'h1234}}, 1'b0, 1, "alias");

    // inputs scrambled every cycle after acceptance
    writeRead(0, 16'h0060, 16'h0060, {8{32'h600D0060}}, 1'b1, 5, "stable");
    writeRead(1, 16'h0060, 16'h0060, {8{32'h600D0060}}, 1'b1, 1, "stable");

    // randomized traffic on both instances in parallel
    fork
      runRandom(0, 60);
      runRandom(1, 120);
    join

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
